acc_multi: RTL and testbench

Multi-channel, runtime-length accumulator. It is the parametrised successor to the single-lane fixed-length 32-bit accumulator.
- Sums `len` samples on each of CH parallel lanes, in signed or unsigned mode.
- Input side is a valid/ready stream; output side is a held valid/ready result.
- Sits between sample sources (ADC/filter outputs) and downstream averaging/control logic.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/acc_lane.sv | 86 ++++++++
 rtl/acc_multi.sv | 117 +++++++++++
 tb/tb_acc_multi.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and helpers for the multi-lane accumulator: FSM states, accumulator width
// and the signed/unsigned clamp bounds used when ACC_SAT_EN is defined.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   // Accumulator width that cannot overflow for max_len samples of width bits.
   function automatic int unsigned acc_width(input int unsigned width,
                                             input int unsigned max_len);
      return width + $clog2(max_len + 1);
   endfunction

   function automatic longint sat_hi(input int unsigned out_w, input logic is_signed);
      return is_signed ? (longint'(1) <<< (out_w - 1)) - longint'(1)
                       : (longint'(1) <<< out_w) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int unsigned out_w, input logic is_signed);
      return is_signed ? -(longint'(1) <<< (out_w - 1)) : longint'(0);
   endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: extend, accumulate, map to OUT_W and capture the result on load.
// Clamping of narrow outputs is built only when ACC_SAT_EN is defined; otherwise it wraps.
module acc_lane
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 13,
   parameter int unsigned OUT_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             add,
   input  logic             load,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] sample,
   output logic [OUT_W-1:0] res,
   output logic             clamp
);

   logic [AW-1:0]    acc_q, acc_d, ext;
   logic [OUT_W-1:0] mapped;

   assign ext = {{(AW - WIDTH){signed_mode & sample[WIDTH-1]}}, sample};

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (add) begin
         acc_d = acc_q + ext;
      end
   end

   generate
      if (OUT_W > AW) begin : g_wide
         assign mapped = {{(OUT_W - AW){signed_mode & acc_d[AW-1]}}, acc_d};
         assign clamp  = 1'b0;
      end else if (OUT_W == AW) begin : g_same
         assign mapped = acc_d;
         assign clamp  = 1'b0;
      end else begin : g_narrow
`ifdef ACC_SAT_EN
         longint acc_s, hi, lo, clamped;
         logic   unused_clamped;

         always_comb begin
            acc_s   = signed_mode ? longint'($signed(acc_d)) : longint'({1'b0, acc_d});
            hi      = sat_hi(OUT_W, signed_mode);
            lo      = sat_lo(OUT_W, signed_mode);
            clamped = acc_s;
            clamp   = 1'b0;
            if (acc_s > hi) begin
               clamped = hi;
               clamp   = 1'b1;
            end else if (acc_s < lo) begin
               clamped = lo;
               clamp   = 1'b1;
            end
         end

         assign mapped         = clamped[OUT_W-1:0];
         assign unused_clamped = ^clamped[63:OUT_W];
`else
         logic unused_acc_hi;

         assign mapped        = acc_d[OUT_W-1:0];
         assign clamp         = 1'b0;
         assign unused_acc_hi = ^acc_d[AW-1:OUT_W];
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         res   <= '0;
      end else begin
         acc_q <= acc_d;
         if (load) begin
            res <= mapped;
         end
      end
   end

endmodule

// File: rtl/acc_multi.sv
// CH-lane runtime-length accumulator with valid/ready input and held valid/ready result.
// Define ACC_SAT_EN to clamp lanes (and raise sat) when OUT_W is narrower than the accumulator.
module acc_multi
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CH      = 4,
   parameter int unsigned OUT_W   = WIDTH + $clog2(MAX_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [$clog2(MAX_LEN+1)-1:0] len,
   input  logic                         signed_mode,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CH*WIDTH-1:0]          in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH*OUT_W-1:0]          out_data,
   output logic                         busy,
   output logic                         cal_done,
   output logic                         sat
);

   localparam int unsigned AW = acc_width(WIDTH, MAX_LEN);
   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] MAX_CNT = LW'(MAX_LEN);

   state_t        state;
   logic [LW-1:0] remaining;
   logic [LW-1:0] eff_len;
   logic          mode_q;
   logic          start_ok, accept, last_beat, load;
   logic [CH-1:0] clamp;

   assign eff_len   = (len > MAX_CNT) ? MAX_CNT : len;
   assign start_ok  = (state == IDLE) & start;
   assign accept    = in_valid & in_ready;
   assign last_beat = accept & (remaining == LW'(1));
   // Capture the result on the edge that enters DONE, so it appears with out_valid.
   assign load      = (start_ok & (len == '0)) | last_beat;

   for (genvar c = 0; c < CH; c++) begin : g_lane
      acc_lane #(
         .WIDTH (WIDTH),
         .AW    (AW),
         .OUT_W (OUT_W)
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear       (start_ok),
         .add         (accept),
         .load        (load),
         .signed_mode (mode_q),
         .sample      (in_data[c*WIDTH +: WIDTH]),
         .res         (out_data[c*OUT_W +: OUT_W]),
         .clamp       (clamp[c])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         mode_q    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cal_done  <= 1'b0;
         sat       <= 1'b0;
      end else begin
         cal_done <= 1'b0;
         if (load) begin
            sat <= |clamp;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= signed_mode;
                  remaining <= eff_len;
                  busy      <= 1'b1;
                  if (len == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     cal_done  <= 1'b1;
                  end else begin
                     state    <= ACC;
                     in_ready <= 1'b1;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LW'(1)) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     cal_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_multi.sv
// Bench for acc_multi: two instances (OUT_W = AW and OUT_W = 10) share stimulus and are
// compared with a plain-arithmetic sum/clamp model; ACC_SAT_EN selects expected narrow mapping.
module tb_acc_multi;

   localparam int W   = 8;
   localparam int ML  = 16;
   localparam int CH  = 4;
   localparam int AW  = 13;
   localparam int OW1 = 13;
   localparam int OW2 = 10;
   localparam int LW  = 5;

`ifdef ACC_SAT_EN
   localparam logic [63:0] T1_L0 = 64'd1023;
   localparam bit          T1_S  = 1'b1;
   localparam logic [63:0] T2_L0 = 64'h200;
   localparam bit          T2_S  = 1'b1;
`else
   localparam logic [63:0] T1_L0 = 64'd1008;
   localparam bit          T1_S  = 1'b0;
   localparam logic [63:0] T2_L0 = 64'd0;
   localparam bit          T2_S  = 1'b0;
`endif

   typedef struct {
      int          n_len;
      bit          sgn;
      int          pattern;
      int          gap;
      int          hold;
      bit          poke;
      bit          has_exp;
      logic [63:0] x1_l0;
      logic [63:0] x1_l1;
      logic [63:0] x2_l0;
      bit          x2_sat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start, signed_mode, in_valid, out_ready;
   logic [LW-1:0] len;
   logic [CH*W-1:0] in_data;
   logic in_ready1, out_valid1, busy1, cal_done1, sat1;
   logic in_ready2, out_valid2, busy2, cal_done2, sat2;
   logic [CH*OW1-1:0] out_data1;
   logic [CH*OW2-1:0] out_data2;

   int n_cmp = 0;
   int n_bad = 0;
   longint sums[CH];
   logic [63:0] e1[CH];
   logic [63:0] e2[CH];
   bit es2;

   always #5 clk = ~clk;

   acc_multi #(.WIDTH(W), .MAX_LEN(ML), .CH(CH), .OUT_W(OW1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .busy(busy1), .cal_done(cal_done1),
      .sat(sat1)
   );

   acc_multi #(.WIDTH(W), .MAX_LEN(ML), .CH(CH), .OUT_W(OW2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .busy(busy2), .cal_done(cal_done2),
      .sat(sat2)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Spec mapping: clamp when narrow and saturation enabled, else two's-complement wrap.
   function automatic logic [63:0] map_res(input longint sum, input int ow, input bit sgn,
                                           output bit s);
      longint v;
      v = sum;
      s = 1'b0;
`ifdef ACC_SAT_EN
      if (ow < AW) begin
         longint hi, lo;
         hi = sgn ? (longint'(1) <<< (ow - 1)) - 1 : (longint'(1) <<< ow) - 1;
         lo = sgn ? -(longint'(1) <<< (ow - 1)) : longint'(0);
         if (v > hi) begin
            v = hi;
            s = 1'b1;
         end else if (v < lo) begin
            v = lo;
            s = 1'b1;
         end
      end
`endif
      return v & ((longint'(1) <<< ow) - 1);
   endfunction

   function automatic logic [W-1:0] pat_val(input int pattern, input int k, input int c);
      case (pattern)
         1:       return 8'hFF;
         2:       return (c == 0) ? 8'h80 : (c == 1) ? ((k % 2 == 0) ? 8'h7F : 8'h80)
                                  : (c == 2) ? 8'h01 : 8'h00;
         3:       return 8'h01;
         default: return W'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      for (int c = 0; c < CH; c++) begin
         chk({tag, "_data1"}, 64'(out_data1[c*OW1 +: OW1]), e1[c]);
         chk({tag, "_data2"}, 64'(out_data2[c*OW2 +: OW2]), e2[c]);
      end
      chk({tag, "_valid1"}, 64'(out_valid1), 64'd1);
      chk({tag, "_valid2"}, 64'(out_valid2), 64'd1);
      chk({tag, "_sat1"}, 64'(sat1), 64'd0);
      chk({tag, "_sat2"}, 64'(sat2), 64'(es2));
   endtask

   task automatic do_frame(input vec_t v);
      int n_exp, acc_cnt, cyc;
      logic [W-1:0] b;
      bit s;
      n_exp = (v.n_len > ML) ? ML : v.n_len;
      for (int c = 0; c < CH; c++) sums[c] = 0;
      // A beat offered alongside start must not be taken.
      start = 1'b1;
      len = LW'(v.n_len);
      signed_mode = v.sgn;
      in_valid = 1'b1;
      in_data = '1;
      chk("idle_in_ready", 64'(in_ready1), 64'd0);
      step();
      start = 1'b0;
      acc_cnt = 0;
      cyc = 0;
      while (acc_cnt < n_exp && cyc < 400) begin
         in_valid = ($urandom_range(0, 99) >= v.gap);
         for (int c = 0; c < CH; c++) begin
            b = pat_val(v.pattern, acc_cnt, c);
            in_data[c*W +: W] = b;
            if (in_valid) sums[c] += v.sgn ? longint'($signed(b)) : longint'(b);
         end
         chk("acc_in_ready1", 64'(in_ready1), 64'd1);
         chk("acc_in_ready2", 64'(in_ready2), 64'd1);
         chk("acc_busy", 64'(busy1), 64'd1);
         chk("acc_out_valid", 64'(out_valid1), 64'd0);
         if (in_valid) acc_cnt++;
         step();
         cyc++;
      end
      if (cyc >= 400) chk("beat_timeout", 64'(acc_cnt), 64'(n_exp));
      es2 = 1'b0;
      for (int c = 0; c < CH; c++) begin
         e1[c] = map_res(sums[c], OW1, v.sgn, s);
         e2[c] = map_res(sums[c], OW2, v.sgn, s);
         es2 |= s;
      end
      in_valid = 1'b1;
      in_data = CH*W'($urandom());
      chk("cal_done_entry", 64'(cal_done1), 64'd1);
      chk("cal_done_entry2", 64'(cal_done2), 64'd1);
      chk("busy_done", 64'(busy1), 64'd1);
      chk("in_ready_done", 64'(in_ready1), 64'd0);
      check_outputs("done");
      if (v.has_exp) begin
         chk("tbl_d1_l0", 64'(out_data1[0 +: OW1]), v.x1_l0);
         chk("tbl_d1_l1", 64'(out_data1[OW1 +: OW1]), v.x1_l1);
         chk("tbl_d2_l0", 64'(out_data2[0 +: OW2]), v.x2_l0);
         chk("tbl_sat2", 64'(sat2), 64'(v.x2_sat));
      end
      for (int h = 0; h < v.hold; h++) begin
         out_ready = 1'b0;
         start = v.poke;
         len = 5'd3;
         step();
         chk("hold_cal_done", 64'(cal_done1), 64'd0);
         chk("hold_in_ready", 64'(in_ready1), 64'd0);
         check_outputs("hold");
      end
      start = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("release_valid1", 64'(out_valid1), 64'd0);
      chk("release_valid2", 64'(out_valid2), 64'd0);
      chk("release_busy", 64'(busy1), 64'd0);
      chk("release_cal_done", 64'(cal_done1), 64'd0);
      step();
      chk("idle_after_in_ready", 64'(in_ready1), 64'd0);
      chk("idle_after_valid", 64'(out_valid1), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready1), 64'd0);
      chk({tag, "_busy"}, 64'(busy1), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid1), 64'd0);
      chk({tag, "_cal_done"}, 64'(cal_done1), 64'd0);
      chk({tag, "_sat2"}, 64'(sat2), 64'd0);
      chk({tag, "_data1"}, 64'(out_data1), 64'd0);
      chk({tag, "_data2"}, 64'(out_data2), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      vec_t rv;
      tbl[0] = '{16, 1'b0, 1, 0, 0, 1'b0, 1'b1, 64'd4080, 64'd4080, T1_L0, T1_S};
      tbl[1] = '{16, 1'b1, 2, 0, 0, 1'b0, 1'b1, 64'd6144, 64'd8184, T2_L0, T2_S};
      tbl[2] = '{16, 1'b0, 3, 40, 5, 1'b1, 1'b1, 64'd16, 64'd16, 64'd16, 1'b0};
      tbl[3] = '{0, 1'b1, 0, 0, 2, 1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 1'b0};
      tbl[4] = '{20, 1'b0, 3, 0, 1, 1'b1, 1'b1, 64'd16, 64'd16, 64'd16, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      len = '0;
      signed_mode = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      step();
      step();
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) do_frame(tbl[i]);

      // Reset after 5 of 16 beats: everything clears at once and the frame is dropped.
      start = 1'b1;
      len = 5'd16;
      signed_mode = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = '1;
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("post_reset_valid", 64'(out_valid1), 64'd0);
         chk("post_reset_in_ready", 64'(in_ready1), 64'd0);
      end
      in_valid = 1'b0;
      do_frame('{16, 1'b0, 3, 0, 0, 1'b0, 1'b1, 64'd16, 64'd16, 64'd16, 1'b0});

      for (int i = 0; i < 20; i++) begin
         rv = '{int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)), 0,
                int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), 1'b0, 64'd0, 64'd0, 64'd0, 1'b0};
         do_frame(rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
